// File: rtl/tube_pkg.sv
// Shared Tube definitions: register addresses, transfer direction and
// the NMI transfer engine state encoding.
package tube_pkg;

    // Parasite-side register addresses on p_addr
    localparam logic [2:0] R1_STAT = 3'b000;
    localparam logic [2:0] R1_DATA = 3'b001;
    localparam logic [2:0] R2_STAT = 3'b010;
    localparam logic [2:0] R2_DATA = 3'b011;
    localparam logic [2:0] R3_STAT = 3'b100;
    localparam logic [2:0] R3_DATA = 3'b101;
    localparam logic [2:0] R4_STAT = 3'b110;
    localparam logic [2:0] R4_DATA = 3'b111;

    // Transfer direction as seen from the parasite
    localparam logic DIR_H2P = 1'b0;   // read R3, write memory
    localparam logic DIR_P2H = 1'b1;   // read memory, write R3

    typedef enum logic [2:0] {
        IDLE,
        MRD,
        WAIT_NMI,
        TACC,
        MWR,
        DONE
    } xfer_state_e;

endpackage

// File: rtl/tube_nmi_xfer_if.sv
// Bus bundle between the NMI transfer engine, the Tube ULA parasite port
// and parasite memory. master = engine, slave = ULA + memory side.
interface tube_nmi_xfer_if #(
    parameter int ADDR_W = 16
);
    // Tube ULA parasite port
    logic              t_nmi_b;
    logic [2:0]        t_addr;
    logic              t_cs_b;
    logic              t_rd_b;
    logic              t_wr_b;
    logic [7:0]        t_din;
    logic [7:0]        t_dout;
    logic              t_doe;
    // Parasite memory port
    logic [ADDR_W-1:0] m_addr;
    logic              m_req;
    logic              m_we;
    logic [7:0]        m_wdata;
    logic [7:0]        m_rdata;
    logic              m_ack;

    modport master (
        input  t_nmi_b, t_din, m_rdata, m_ack,
        output t_addr, t_cs_b, t_rd_b, t_wr_b, t_dout, t_doe,
               m_addr, m_req, m_we, m_wdata
    );

    modport slave (
        output t_nmi_b, t_din, m_rdata, m_ack,
        input  t_addr, t_cs_b, t_rd_b, t_wr_b, t_dout, t_doe,
               m_addr, m_req, m_we, m_wdata
    );
endinterface

// File: rtl/tube_sync.sv
// N-flop synchroniser for an asynchronous level; flops reset to 1 so an
// active-low input reads as deasserted straight out of reset.
module tube_sync #(
    parameter int N = 2
) (
    input  logic p_clk,
    input  logic p_rst,
    input  logic d_i,
    output logic q_o
);
    logic [N-1:0] sync_q;

    // Shift the raw input through N flops
    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < N; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[N-1];
endmodule

// File: rtl/tube_nmi_xfer.sv
// Parasite-side Tube register-3 NMI transfer engine. Each R3 NMI moves one
// byte between R3 data and parasite memory, H2P or P2H, with an address
// pointer and byte counter and a guard window against stale NMI levels.
module tube_nmi_xfer
    import tube_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int STROBE_CYCLES = 2,
    parameter int SYNC_STAGES   = 2,
    parameter int GUARD_CYCLES  = 3
) (
    input  logic              p_clk,
    input  logic              p_rst,
    input  logic              start,
    input  logic              dir,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [15:0]       length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    tube_nmi_xfer_if.master   bus
);
    localparam int PH_W = $clog2(STROBE_CYCLES + 1);
    localparam int GD_W = $clog2(GUARD_CYCLES + 1);

    xfer_state_e       state_q;
    logic              dir_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [15:0]       cnt_q;
    logic [7:0]        buf_q;
    logic [PH_W-1:0]   ph_q;
    logic [GD_W-1:0]   guard_q;
    logic              busy_q, done_q, aborted_q;
    logic              t_cs_b_q, t_rd_b_q, t_wr_b_q, t_doe_q;
    logic [2:0]        t_addr_q;
    logic [7:0]        t_dout_q;
    logic              m_req_q, m_we_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [7:0]        m_wdata_q;

    logic              nmi_b_s;
    logic              nmi_s;
    logic [ADDR_W-1:0] ptr_d;
    logic [15:0]       cnt_d;
    logic              last_byte;

    tube_sync #(.N(SYNC_STAGES)) u_nmi_sync (
        .p_clk (p_clk),
        .p_rst (p_rst),
        .d_i   (bus.t_nmi_b),
        .q_o   (nmi_b_s)
    );

    assign nmi_s     = ~nmi_b_s;
    assign ptr_d     = ptr_q + 1'b1;         // wraps modulo 2^ADDR_W
    assign cnt_d     = cnt_q - 16'd1;
    assign last_byte = (cnt_q == 16'd1);     // tested before decrement

    // Transfer FSM with all outputs registered
    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            state_q   <= IDLE;
            dir_q     <= DIR_H2P;
            ptr_q     <= '0;
            cnt_q     <= '0;
            buf_q     <= '0;
            ph_q      <= '0;
            guard_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            t_cs_b_q  <= 1'b1;
            t_rd_b_q  <= 1'b1;
            t_wr_b_q  <= 1'b1;
            t_doe_q   <= 1'b0;
            t_addr_q  <= R1_STAT;
            t_dout_q  <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            // NOTE: defaults first, later non-blocking assignments in the
            // same block override them (e.g. the guard reload in TACC).
            done_q <= 1'b0;
            if (guard_q != '0) guard_q <= guard_q - 1'b1;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        dir_q     <= dir;
                        ptr_q     <= start_addr;
                        cnt_q     <= length;
                        aborted_q <= 1'b0;
                        busy_q    <= 1'b1;
                        if (length == 16'd0)    state_q <= DONE;
                        else if (dir == DIR_H2P) state_q <= WAIT_NMI;
                        else                     state_q <= MRD;
                    end
                end

                MRD: begin
                    if (!m_req_q) begin
                        // Abort is only safe before the request goes out
                        if (abort) begin
                            aborted_q <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            m_req_q  <= 1'b1;
                            m_we_q   <= 1'b0;
                            m_addr_q <= ptr_q;
                        end
                    end else if (bus.m_ack) begin
                        buf_q   <= bus.m_rdata;
                        m_req_q <= 1'b0;
                        state_q <= WAIT_NMI;
                    end
                end

                WAIT_NMI: begin
                    if (abort) begin
                        aborted_q <= 1'b1;
                        state_q   <= DONE;
                    end else if (nmi_s && guard_q == '0) begin
                        state_q  <= TACC;
                        ph_q     <= '0;
                        t_cs_b_q <= 1'b0;
                        t_addr_q <= R3_DATA;
                        if (dir_q == DIR_H2P) begin
                            t_rd_b_q <= 1'b0;
                        end else begin
                            t_wr_b_q <= 1'b0;
                            t_doe_q  <= 1'b1;
                            t_dout_q <= buf_q;
                        end
                    end
                end

                TACC: begin
                    if (ph_q < PH_W'(STROBE_CYCLES - 1)) begin
                        ph_q <= ph_q + 1'b1;
                    end else if (ph_q == PH_W'(STROBE_CYCLES - 1)) begin
                        // Last strobe-low cycle: sample R3 and release strobe,
                        // chip select and data stay for one hold cycle
                        if (dir_q == DIR_H2P) buf_q <= bus.t_din;
                        t_rd_b_q <= 1'b1;
                        t_wr_b_q <= 1'b1;
                        ph_q     <= ph_q + 1'b1;
                    end else begin
                        t_cs_b_q <= 1'b1;
                        t_doe_q  <= 1'b0;
                        t_addr_q <= R1_STAT;
                        guard_q  <= GD_W'(GUARD_CYCLES);
                        if (dir_q == DIR_H2P) begin
                            state_q <= MWR;
                        end else begin
                            ptr_q   <= ptr_d;
                            cnt_q   <= cnt_d;
                            state_q <= last_byte ? DONE : MRD;
                        end
                    end
                end

                MWR: begin
                    if (!m_req_q) begin
                        m_req_q   <= 1'b1;
                        m_we_q    <= 1'b1;
                        m_addr_q  <= ptr_q;
                        m_wdata_q <= buf_q;
                    end else if (bus.m_ack) begin
                        m_req_q <= 1'b0;
                        m_we_q  <= 1'b0;
                        ptr_q   <= ptr_d;
                        cnt_q   <= cnt_d;
                        state_q <= last_byte ? DONE : WAIT_NMI;
                    end
                end

                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign bus.t_addr  = t_addr_q;
    assign bus.t_cs_b  = t_cs_b_q;
    assign bus.t_rd_b  = t_rd_b_q;
    assign bus.t_wr_b  = t_wr_b_q;
    assign bus.t_dout  = t_dout_q;
    assign bus.t_doe   = t_doe_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_wdata = m_wdata_q;
endmodule

// File: doc/tube_nmi_xfer.md
Name: tube_nmi_xfer

Overview:
- Parasite-side engine sitting directly downstream of the Tube ULA's parasite port; it consumes the ULA's p_nmi_b output.
- On each register-3 NMI it moves one byte between register-3 data (p_addr 3'b101) and parasite memory, with no CPU intervention.
- It performs host-to-parasite (H2P) and parasite-to-host (P2H) block transfers with an address pointer and byte counter.
- It acts as a bus master on the ULA's p_cs_b/p_rd_b/p_wr_b strobe interface.

Parameters:
- ADDR_W, 16: memory address width.
- STROBE_CYCLES, 2: clock cycles that t_rd_b/t_wr_b are held low (minimum 1).
- SYNC_STAGES, 2: synchroniser depth on t_nmi_b.
- GUARD_CYCLES, 3: idle cycles after each Tube access before NMI is re-sampled; must be ≥ SYNC_STAGES+1.

Ports:
- p_clk  in  1  sole clock.
- p_rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse; accepted only when busy=0.
- dir  in  1  0=H2P (read R3, write mem); 1=P2H (read mem, write R3). Sampled at start.
- start_addr  in  ADDR_W  first memory address. Sampled at start.
- length  in  16  byte count. Sampled at start.
- abort  in  1  level; terminates the transfer at the next safe point.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at completion or abort.
- aborted  out  1  set with done when the transfer was aborted; cleared on the next start.
- t_nmi_b  in  1  ULA p_nmi_b; asynchronous, pulled up externally.
- t_addr  out  3  ULA p_addr; driven 3'b101 during accesses.
- t_cs_b  out  1  ULA p_cs_b.
- t_rd_b  out  1  ULA p_rd_b.
- t_wr_b  out  1  ULA p_wr_b.
- t_din  in  8  ULA p_data read path.
- t_dout  out  8  ULA p_data write value.
- t_doe  out  1  enable for the external p_data tristate.
- m_addr  out  ADDR_W  memory address.
- m_req  out  1  memory request; held until m_ack.
- m_we  out  1  memory write enable.
- m_wdata  out  8  memory write data.
- m_rdata  in  8  memory read data, valid with m_ack.
- m_ack  in  1  one-cycle memory acknowledge.

Behaviour:
- Reset values: busy=0, done=0, aborted=0, t_cs_b=1, t_rd_b=1, t_wr_b=1, t_doe=0, t_addr=3'b000, m_req=0, m_we=0, all data/address outputs 0, state=IDLE, synchroniser flops=1.
- nmi_s = inverted output of the SYNC_STAGES synchroniser on t_nmi_b; 1 means NMI asserted.
- IDLE: on start, latch dir, ptr=start_addr, cnt=length.
  - length=0: next state DONE (done pulses 2 cycles after start, busy high 1 cycle).
  - length≠0 and dir=0: next state WAIT_NMI.
  - length≠0 and dir=1: next state MRD.
- MRD (P2H prefetch): m_req=1, m_we=0, m_addr=ptr. On m_ack, capture m_rdata into buf and go to WAIT_NMI.
- WAIT_NMI: hold while nmi_s=0. When nmi_s=1 and guard counter=0, go to TACC.
- TACC:
  - Cycle 1: t_cs_b=0, t_addr=101. Strobe low for STROBE_CYCLES cycles: t_rd_b for H2P; t_wr_b for P2H, with t_doe=1 and t_dout=buf.
  - H2P: t_din is captured into buf on the last strobe-low cycle.
  - Then strobe high with t_cs_b still 0 and t_doe still 1 for one hold cycle (the ULA latches on the p_wr_b rising edge).
  - Then t_cs_b=1, t_doe=0. Load guard=GUARD_CYCLES; guard decrements every cycle it is nonzero.
- After TACC:
  - H2P: go to MWR.
  - P2H: ptr+1, cnt-1; next state is DONE if cnt becomes 0, otherwise MRD.
- MWR: m_req=1, m_we=1, m_addr=ptr, m_wdata=buf. On m_ack, ptr+1 and cnt-1; next state is DONE if cnt reaches 0, otherwise WAIT_NMI.
- DONE: done=1 for one cycle, busy falls the same cycle, return to IDLE.
- ptr wraps modulo 2^ADDR_W. cnt never underflows; it is tested before decrement.
- Abort:
  - Honoured only in WAIT_NMI, or in MRD before m_req is issued; next state DONE with aborted=1.
  - Never cut off a TACC strobe or an outstanding m_req.
  - Abort arriving in the same cycle as a completing final byte: done with aborted=0.
- start while busy is ignored.
- p_rst at any state forces the reset values on the next edge, including mid-strobe (strobes return high).

Decomposition:
- Shared package tube_pkg: register address constants (R1_DATA=3'b001, R3_STAT=3'b100, R3_DATA=3'b101, etc.), the xfer state enum (IDLE, MRD, WAIT_NMI, TACC, MWR, DONE), and the direction constants.
- One sub-module: tube_sync (parameterised N-flop synchroniser with reset value 1), instantiated for t_nmi_b.

Test Plan:
- H2P, start_addr=16'h0400, length=3; bench ULA model asserts NMI with R3 bytes 8'hA5, 8'h5A, 8'hFF → memory writes 0400=A5, 0401=5A, 0402=FF; exactly 3 read strobes at t_addr=101; single done pulse; aborted=0.
- P2H, start_addr=16'hFFFF, length=2; mem FFFF=8'h12, 0000=8'h34 → R3 writes 12 then 34; m_addr wraps to 0000; t_wr_b rises while t_cs_b=0 and t_dout is valid.
- length=0 → done exactly 2 cycles after start; no strobes, no m_req.
- NMI held asserted continuously (model deasserts it late) → consecutive accesses separated by ≥GUARD_CYCLES idle cycles; no double read of one byte.
- abort during WAIT_NMI after 1 of 4 bytes → done with aborted=1; one memory write; further start accepted.
- p_rst asserted mid-strobe in TACC → next edge: t_cs_b=t_rd_b=t_wr_b=1, busy=0, m_req=0; start pulse while busy ignored (no re-latch of start_addr).
